dualrail_srlatch_bank: RTL and testbench



---
 rtl/dualrail_srlatch_bank_pkg.sv | 14 +
 rtl/dualrail_srlatch_bank_completion.sv | 19 +
 rtl/dualrail_srlatch_bank.sv | 92 +++++++++
 tb/tb_dualrail_srlatch_bank.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/dualrail_srlatch_bank_pkg.sv
// srlatch_dr_pkg: FSM states, rail codes, S=R=1 resolution modes and the per-channel next-state rule.
package srlatch_dr_pkg;
  typedef enum logic [2:0] {IDLE, EVAL, DRIVE, WAIT_NULL, RTZ} fsm_t;
  localparam logic [1:0] NULL = 2'b00;
  localparam logic [1:0] ZERO = 2'b01;
  localparam logic [1:0] ONE  = 2'b10;
  localparam logic [1:0] ILL  = 2'b11;
  localparam int HOLD = 0;
  localparam int SET_DOM = 1;
  localparam int RST_DOM = 2;
  function automatic logic next_state(input logic s, r, cur, input int mode);
    return (s ^ r) ? s : (!s || mode == HOLD) ? cur : mode == SET_DOM ? 1'b1 : mode == RST_DOM ? 1'b0 : cur;
  endfunction
endpackage

// File: rtl/dualrail_srlatch_bank_completion.sv
// dr_completion: completion detection (all valid / all null / per-pair illegal) over W dual-rail pairs.
module dr_completion import srlatch_dr_pkg::*; #(
  parameter int W = 2
) (
  input  logic [W-1:0] t,
  input  logic [W-1:0] f,
  output logic         all_valid,
  output logic         all_null,
  output logic [W-1:0] ill
);
  logic [W-1:0] v, z;
  for (genvar i = 0; i < W; i++) begin : g
    assign v[i] = {t[i], f[i]} == ZERO || {t[i], f[i]} == ONE;
    assign z[i] = {t[i], f[i]} == NULL;
    assign ill[i] = {t[i], f[i]} == ILL;
  end
  assign all_valid = &v;
  assign all_null = &z;
endmodule

// File: rtl/dualrail_srlatch_bank.sv
// dualrail_srlatch_bank: N dual-rail SR latch channels sharing one four-phase return-to-zero handshake.
module dualrail_srlatch_bank import srlatch_dr_pkg::*; #(
  parameter int   N          = 4,
  parameter int   EVAL_DLY   = 5,
  parameter int   NULL_DLY   = 5,
  parameter int   BOTH_MODE  = 0,
  parameter logic INIT_STATE = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] s_t,
  input  logic [N-1:0] s_f,
  input  logic [N-1:0] r_t,
  input  logic [N-1:0] r_f,
  output logic [N-1:0] q_t,
  output logic [N-1:0] q_f,
  output logic [N-1:0] state_o,
  output logic         busy,
  output logic         err,
  output logic [N-1:0] err_ch
);
  localparam int CW = $clog2((EVAL_DLY > NULL_DLY ? EVAL_DLY : NULL_DLY) + 1);
  localparam logic [CW-1:0] EMAX = CW'(EVAL_DLY);
  localparam logic [CW-1:0] NMAX = CW'(NULL_DLY);
  fsm_t st;
  logic [CW-1:0] cnt;
  logic [N-1:0] snap_s, snap_r, nxt;
  logic all_valid, all_null, same;
  logic [2*N-1:0] ill;
  dr_completion #(.W(2*N)) u_comp (
    .t(({r_t, s_t})),
    .f(({r_f, s_f})),
    .all_valid(all_valid),
    .all_null(all_null),
    .ill(ill)
  );
  assign same = {s_t, r_t} == {snap_s, snap_r};
  assign busy = st != IDLE;
  always_comb begin
    nxt = state_o;
    for (int i = 0; i < N; i++) nxt[i] = next_state(s_t[i], r_t[i], state_o[i], BOTH_MODE);
  end
  // q is registered on entry to DRIVE and RTZ, so each is a one-cycle bookkeeping state.
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= IDLE;
      cnt <= '0;
      q_t <= '0;
      q_f <= '0;
      state_o <= {N{INIT_STATE}};
      err <= 1'b0;
      err_ch <= '0;
      snap_s <= '0;
      snap_r <= '0;
    end else begin
      err <= err | (|ill);
      err_ch <= err_ch | ill[N-1:0] | ill[2*N-1:N];
      case (st)
        IDLE: if (all_valid) begin
          st <= EVAL;
          cnt <= CW'(1);
          snap_s <= s_t;
          snap_r <= r_t;
        end
        EVAL: if (!all_valid) begin
          st <= IDLE;
          cnt <= '0;
        end else if (!same) begin
          cnt <= CW'(1);
          snap_s <= s_t;
          snap_r <= r_t;
        end else if (cnt == EMAX) begin
          st <= DRIVE;
          cnt <= '0;
          state_o <= nxt;
          q_t <= nxt;
          q_f <= ~nxt;
        end else cnt <= cnt + 1'b1;
        DRIVE: st <= WAIT_NULL;
        WAIT_NULL: if (!all_null) cnt <= '0;
        else if (cnt == NMAX) begin
          st <= RTZ;
          cnt <= '0;
          q_t <= '0;
          q_f <= '0;
        end else cnt <= cnt + 1'b1;
        RTZ: st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dualrail_srlatch_bank.sv
// tb_dualrail_srlatch_bank: three banks (hold / set-dominant / reset-dominant) against a stable-run reference model.
module tb_dualrail_srlatch_bank;
  localparam int N = 2;
  localparam int ED = 5;
  localparam int ND = 5;
  logic clk = 0;
  logic reset = 1;
  logic [N-1:0] s_t = '0, s_f = '0, r_t = '0, r_f = '0;
  logic [N-1:0] qt[3], qf[3], so[3], ec[3];
  logic bz[3], er[3];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always #5 clk = ~clk;
  for (genvar m = 0; m < 3; m++) begin : g
    dualrail_srlatch_bank #(.N(N), .EVAL_DLY(ED), .NULL_DLY(ND), .BOTH_MODE(m), .INIT_STATE(1'b0)) u (
      .clk(clk), .reset(reset), .s_t(s_t), .s_f(s_f), .r_t(r_t), .r_f(r_f),
      .q_t(qt[m]), .q_f(qf[m]), .state_o(so[m]), .busy(bz[m]), .err(er[m]), .err_ch(ec[m])
    );
  end
  function automatic logic rule(input logic s, r, c, input int m);
    if (s && !r) return 1'b1;
    if (!s && r) return 1'b0;
    if (!s && !r) return c;
    return m == 1 ? 1'b1 : m == 2 ? 1'b0 : c;
  endfunction
  // ph: 0 collecting a stable valid run, 1 dead cycle after commit, 2 collecting a null run, 3 dead cycle after RTZ
  int ph, run, nrun;
  logic qon, mer;
  logic [N-1:0] sn_s, sn_r, mec;
  logic [N-1:0] ms[3];
  always @(posedge clk) begin
    logic v, z;
    cyc++;
    v = 1'b1;
    z = 1'b1;
    for (int i = 0; i < N; i++) begin
      v = v && (s_t[i] != s_f[i]) && (r_t[i] != r_f[i]);
      z = z && !(s_t[i] || s_f[i] || r_t[i] || r_f[i]);
    end
    if (reset) begin
      ph = 0; run = 0; nrun = 0; qon = 0; mer = 0; mec = '0;
      for (int m = 0; m < 3; m++) ms[m] = '0;
    end else begin
      mec = mec | (s_t & s_f) | (r_t & r_f);
      mer = mer | (|mec);
      if (ph == 0) begin
        if (!v) run = 0;
        else begin
          if (run > 0 && s_t == sn_s && r_t == sn_r) run++;
          else begin
            run = 1; sn_s = s_t; sn_r = r_t;
          end
          if (run == ED + 1) begin
            for (int m = 0; m < 3; m++)
              for (int i = 0; i < N; i++) ms[m][i] = rule(s_t[i], r_t[i], ms[m][i], m);
            qon = 1; ph = 1; run = 0;
          end
        end
      end else if (ph == 1) begin
        ph = 2; nrun = 0;
      end else if (ph == 2) begin
        nrun = z ? nrun + 1 : 0;
        if (nrun == ND + 1) begin
          qon = 0; ph = 3;
        end
      end else ph = 0;
    end
  end
  always @(negedge clk) begin
    logic [N-1:0] eqt, eqf;
    logic [4*N+1:0] act, exp;
    if (cyc > 0)
      for (int m = 0; m < 3; m++) begin
        eqt = qon ? ms[m] : {N{1'b0}};
        eqf = qon ? ~ms[m] : {N{1'b0}};
        exp = {eqt, eqf, ms[m], (ph != 0 || run > 0), mer, mec};
        act = {qt[m], qf[m], so[m], bz[m], er[m], ec[m]};
        checks++;
        if (act !== exp) begin
          errors++;
          $display("FAIL cycle %0d mode %0d outputs {qt,qf,state,busy,err,err_ch} act=%b exp=%b", cyc, m, act, exp);
        end
      end
  end
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, a, e);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic val(input logic [N-1:0] s, input logic [N-1:0] r, input int n);
    s_t = s; s_f = ~s; r_t = r; r_f = ~r;
    tick(n);
  endtask
  task automatic nul(input int n);
    s_t = '0; s_f = '0; r_t = '0; r_f = '0;
    tick(n);
  endtask
  initial begin
    logic [N-1:0] a, b, c, d;
    int k;
    nul(2);
    reset = 0;
    chk("rst_q", 32'({qt[0], qf[0]}), 0);
    chk("rst_state", 32'(so[0]), 0);
    chk("rst_busy", 32'(bz[0]), 0);
    val(2'b01, 2'b10, 5);
    chk("t1_not_yet", 32'(qt[0]), 0);
    chk("t1_busy", 32'(bz[0]), 1);
    val(2'b01, 2'b10, 1);
    chk("t1_qt", 32'(qt[0]), 1);
    chk("t1_qf", 32'(qf[0]), 2);
    chk("t1_state", 32'(so[0]), 1);
    nul(6);
    chk("t1_held", 32'(qt[0]), 1);
    nul(1);
    chk("t1_rtz_q", 32'({qt[0], qf[0]}), 0);
    chk("t1_rtz_busy", 32'(bz[0]), 1);
    nul(1);
    chk("t1_idle", 32'(bz[0]), 0);
    val(2'b11, 2'b00, 6);
    nul(8);
    chk("t2_set", 32'(so[0]), 3);
    val(2'b00, 2'b00, 6);
    chk("t2_hold_q", 32'(qt[0]), 3);
    chk("t2_hold_state", 32'(so[0]), 3);
    nul(8);
    val(2'b00, 2'b11, 6);
    nul(8);
    val(2'b01, 2'b01, 6);
    chk("t3_hold_mode", 32'(so[0]), 0);
    chk("t3_set_dom", 32'(so[1]), 1);
    chk("t3_rst_dom", 32'(so[2]), 0);
    nul(8);
    val(2'b01, 2'b00, 3);
    val(2'b10, 2'b00, 5);
    chk("t4_restart", 32'(qt[0]), 0);
    val(2'b10, 2'b00, 1);
    chk("t4_driven", 32'(qt[0]), 2);
    nul(8);
    val(2'b11, 2'b00, 3);
    nul(10);
    chk("t4_abort_busy", 32'(bz[0]), 0);
    chk("t4_abort_q", 32'(qt[0]), 0);
    chk("t4_abort_state", 32'(so[0]), 2);
    s_t = 2'b10; s_f = 2'b10; r_t = 2'b00; r_f = 2'b00;
    tick(1);
    chk("t5_err", 32'(er[0]), 1);
    chk("t5_err_ch", 32'(ec[0]), 2);
    nul(10);
    chk("t5_err_sticky", 32'(ec[0]), 2);
    chk("t5_no_commit", 32'(so[0]), 2);
    for (int seg = 0; seg < 300; seg++) begin
      k = int'($urandom_range(0, 15));
      if (k == 15 && $urandom_range(0, 3) == 0) begin
        reset = 1;
        tick(1);
        reset = 0;
      end else if (k == 0) begin
        a = N'($urandom); b = N'($urandom); c = N'($urandom); d = N'($urandom);
        s_t = a; s_f = b; r_t = c; r_f = d;
        tick(int'($urandom_range(1, 3)));
      end else if (k < 6) nul(int'($urandom_range(1, 9)));
      else val(N'($urandom), N'($urandom), int'($urandom_range(1, 9)));
    end
    reset = 1;
    tick(1);
    reset = 0;
    val(2'b11, 2'b00, 6);
    val(2'b11, 2'b00, 2);
    chk("t6_qt", 32'(qt[0]), 3);
    chk("t6_busy", 32'(bz[0]), 1);
    s_t = 2'b11; s_f = 2'b01; r_t = 2'b00; r_f = 2'b11;
    tick(1);
    chk("t6_err", 32'(er[0]), 1);
    reset = 1;
    tick(1);
    chk("t6_rst_q", 32'({qt[0], qf[0]}), 0);
    chk("t6_rst_state", 32'(so[0]), 0);
    chk("t6_rst_busy", 32'(bz[0]), 0);
    chk("t6_rst_err", 32'({er[0], ec[0]}), 0);
    reset = 0;
    nul(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
